// File: rtl/bus_cycle_fsm_if.sv
// Processor bus strobes in, device read/write enables out.
// The master side drives the decoded address-phase and strobe signals; the slave side is the cycle FSM.
interface bus_cycle_fsm_if;
    logic CS;
    logic IOM;
    logic RD;
    logic WR;
    logic ALE;
    logic rd;
    logic wr;

    modport master (output CS, IOM, RD, WR, ALE, input rd, wr);
    modport slave  (input CS, IOM, RD, WR, ALE, output rd, wr);
endinterface

// File: rtl/bus_cycle_fsm.sv
// Turns processor ALE/RD/WR bus cycles into device rd (strobe length) and wr (single clock) enables.
// Outputs are Moore-decoded one clock behind the sampled strobe; there is no backpressure, the processor bus paces everything.
module bus_cycle_fsm #(
    parameter bit IS_IO = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET,
    bus_cycle_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        WEND  = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   match;

    // IOM and CS are only meaningful while the address is latched.
    assign match = bus.ALE && bus.CS && (bus.IOM == IS_IO);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (match) begin
                    state_nxt = SEL;
                end
            end
            SEL: begin
                // Read takes priority when both strobes are seen together.
                if (!bus.RD) begin
                    state_nxt = READ;
                end else if (!bus.WR) begin
                    state_nxt = WRITE;
                end else if (bus.ALE) begin
                    state_nxt = match ? SEL : IDLE;
                end
            end
            READ: begin
                if (bus.RD) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                state_nxt = WEND;
            end
            WEND: begin
                if (bus.WR) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        case (state)
            READ:    bus.rd = 1'b1;
            WRITE:   bus.wr = 1'b1;
            default: begin
                bus.rd = 1'b0;
                bus.wr = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_fsm.sv
// Directed bench: one memory-mapped and one I/O-mapped instance share the same bus stimulus.
module tb_bus_cycle_fsm;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    bus_cycle_fsm_if bus_mem ();
    bus_cycle_fsm_if bus_io ();

    bus_cycle_fsm #(.IS_IO(1'b0)) dut_mem (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_mem)
    );

    bus_cycle_fsm #(.IS_IO(1'b1)) dut_io (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus_io)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic ale, input logic cs, input logic iom,
                         input logic rd_n, input logic wr_n);
        bus_mem.ALE = ale;  bus_io.ALE = ale;
        bus_mem.CS  = cs;   bus_io.CS  = cs;
        bus_mem.IOM = iom;  bus_io.IOM = iom;
        bus_mem.RD  = rd_n; bus_io.RD  = rd_n;
        bus_mem.WR  = wr_n; bus_io.WR  = wr_n;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Checks rd/wr of both instances in one go.
    task automatic chk4(input string tag, input logic mrd, input logic mwr,
                        input logic ird, input logic iwr);
        chk({tag, ".mem_rd"}, bus_mem.rd, mrd);
        chk({tag, ".mem_wr"}, bus_mem.wr, mwr);
        chk({tag, ".io_rd"},  bus_io.rd,  ird);
        chk({tag, ".io_wr"},  bus_io.wr,  iwr);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1 RESET = 1'b1;
        #1 chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk4("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // Memory read, RD low for three sampled edges.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("mrd_sel", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("mrd_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk4("mrd_c2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk4("mrd_c3", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("mrd_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // I/O write, WR low for three edges; wr is a single clock.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk4("iowr_sel", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk4("iowr_c1", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("iowr_c2", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk4("iowr_c3", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("iowr_end", 1'b0, 1'b0, 1'b0, 1'b0);
        // Back in IDLE: a strobe without ALE must do nothing.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk4("iowr_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // IOM mismatch for the memory instance; the I/O instance does answer.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("mismatch", 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("mismatch_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Deselected cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("deselect", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Both strobes sampled together: read wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk4("both_strobes", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk4("both_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // CS dropping after the ALE sample is ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk4("cs_late_drop", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // New ALE while in SEL with no strobe: non-matching address abandons the cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("sel_realign_miss", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // New matching ALE while in SEL keeps the cycle alive.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("sel_realign_hit", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        // Asynchronous reset in the middle of a read strobe.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk4("rst_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        #2 RESET = 1'b1;
        #1 chk4("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 RESET = 1'b0;
        tick();
        chk4("rst_no_ale1", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk4("rst_no_ale2", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
